// File: rtl/irq_pending_latch.sv
// irq_pending_latch
//   Upstream stage of the 8:3 priority encoder. Synchronises eight
//   asynchronous request lines and detects events (rising edges or levels).
//   It holds each event as a sticky pending bit until the consumer
//   acknowledges it with the encoder index.
//
// Parameters
//   SYNC_STAGES : synchroniser depth per line (2..4)
//   EDGE_MODE   : 1 = rising-edge capture, 0 = level capture
//
// Ports
//   clk         : clock, all state on rising edge
//   rst         : synchronous active-high reset
//   irq_in      : asynchronous request lines, bit i = channel i
//   mask        : per-channel visibility on pending/any_pending
//   ack_valid   : one-cycle acknowledge strobe
//   ack_idx     : channel being acknowledged (7 = bit 7)
//   ovf_clr     : clears all overflow flags
//   pending     : raw_pending & mask, feeds the encoder
//   any_pending : OR of pending
//   raw_pending : registered pending bits before masking
//   overflow    : sticky per-channel lost-event flags
module irq_pending_latch #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          EDGE_MODE   = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] irq_in,
  input  logic [7:0] mask,
  input  logic       ack_valid,
  input  logic [2:0] ack_idx,
  input  logic       ovf_clr,
  output logic [7:0] pending,
  output logic       any_pending,
  output logic [7:0] raw_pending,
  output logic [7:0] overflow
);

  // sync_q[0] samples irq_in; sync_q[SYNC_STAGES-1] is the synchronised line.
  logic [SYNC_STAGES-1:0][7:0] sync_q;
  logic [7:0]                  prev_q;
  logic [7:0]                  raw_q, raw_d;
  logic [7:0]                  ovf_q, ovf_d;
  logic [7:0]                  sync_w;
  logic [7:0]                  ev;
  logic [7:0]                  clr;
  logic [7:0]                  ovf_set;

  assign sync_w = sync_q[SYNC_STAGES-1];

  always_comb begin
    ev      = '0;
    clr     = '0;
    ovf_set = '0;
    raw_d   = raw_q;
    ovf_d   = ovf_q;

    if (EDGE_MODE) begin
      ev = sync_w & ~prev_q;
    end else begin
      ev = sync_w;
    end

    for (int unsigned i = 0; i < 8; i++) begin
      clr[i] = ack_valid && (ack_idx == 3'(i));
    end

    // Set wins over a simultaneous ack so a fresh event is never dropped.
    raw_d = ev | (raw_q & ~clr);

    // A level line re-asserts every cycle by design, so it never counts as lost.
    if (EDGE_MODE) begin
      ovf_set = ev & raw_q & ~clr;
    end

    ovf_d = ovf_set | (ovf_clr ? 8'h00 : ovf_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= '0;
      raw_q  <= '0;
      ovf_q  <= '0;
    end else begin
      if (SYNC_STAGES > 1) begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], irq_in};
      end else begin
        sync_q <= irq_in;
      end
      prev_q <= sync_w;
      raw_q  <= raw_d;
      ovf_q  <= ovf_d;
    end
  end

  assign raw_pending = raw_q;
  assign overflow    = ovf_q;
  assign pending     = raw_q & mask;
  assign any_pending = |(raw_q & mask);

endmodule

// File: tb/tb_irq_pending_latch.sv
module tb_irq_pending_latch;

  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] irq_in;
  logic [7:0] mask;
  logic       ack_valid;
  logic [2:0] ack_idx;
  logic       ovf_clr;

  logic [7:0] pend_e, raw_e, ovf_e;
  logic       any_e;
  logic [7:0] pend_l, raw_l, ovf_l;
  logic       any_l;

  int checks   = 0;
  int failures = 0;
  bit started  = 1'b0;

  always #5 clk = ~clk;

  irq_pending_latch #(.SYNC_STAGES(S), .EDGE_MODE(1'b1)) u_e (
    .clk(clk), .rst(rst), .irq_in(irq_in), .mask(mask),
    .ack_valid(ack_valid), .ack_idx(ack_idx), .ovf_clr(ovf_clr),
    .pending(pend_e), .any_pending(any_e), .raw_pending(raw_e), .overflow(ovf_e)
  );

  irq_pending_latch #(.SYNC_STAGES(S), .EDGE_MODE(1'b0)) u_l (
    .clk(clk), .rst(rst), .irq_in(irq_in), .mask(mask),
    .ack_valid(ack_valid), .ack_idx(ack_idx), .ovf_clr(ovf_clr),
    .pending(pend_l), .any_pending(any_l), .raw_pending(raw_l), .overflow(ovf_l)
  );

  // Reference model: history of irq_in samples taken at each clock edge.
  // hist[0] is the newest sample; the line becomes visible S-1 samples later.
  logic [7:0] hist [0:S];
  logic [7:0] m_raw_e, m_ovf_e, m_raw_l, m_ovf_l;
  logic [7:0] m_ev_e, m_ev_l;

  assign m_ev_e = hist[S-1] & ~hist[S];
  assign m_ev_l = hist[S-1];

  always @(posedge clk) begin
    started <= 1'b1;
    if (rst) begin
      for (int k = 0; k <= S; k++) hist[k] <= 8'h00;
      m_raw_e <= 8'h00; m_ovf_e <= 8'h00;
      m_raw_l <= 8'h00; m_ovf_l <= 8'h00;
    end else begin
      hist[0] <= irq_in;
      for (int k = 1; k <= S; k++) hist[k] <= hist[k-1];
      for (int i = 0; i < 8; i++) begin
        // edge mode
        if (m_ev_e[i]) begin
          m_raw_e[i] <= 1'b1;
          if (m_raw_e[i] && !(ack_valid && ack_idx == i[2:0])) m_ovf_e[i] <= 1'b1;
          else if (ovf_clr) m_ovf_e[i] <= 1'b0;
        end else begin
          if (ack_valid && ack_idx == i[2:0]) m_raw_e[i] <= 1'b0;
          if (ovf_clr) m_ovf_e[i] <= 1'b0;
        end
        // level mode: no overflow ever
        if (m_ev_l[i]) m_raw_l[i] <= 1'b1;
        else if (ack_valid && ack_idx == i[2:0]) m_raw_l[i] <= 1'b0;
        m_ovf_l[i] <= 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("e_pending",  pend_e, m_raw_e & mask);
      chk("e_any",      {7'd0, any_e}, {7'd0, |(m_raw_e & mask)});
      chk("e_raw",      raw_e,  m_raw_e);
      chk("e_overflow", ovf_e,  m_ovf_e);
      chk("l_pending",  pend_l, m_raw_l & mask);
      chk("l_any",      {7'd0, any_l}, {7'd0, |(m_raw_l & mask)});
      chk("l_raw",      raw_l,  m_raw_l);
      chk("l_overflow", ovf_l,  m_ovf_l);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic ack_all();
    for (int i = 0; i < 8; i++) begin
      ack_valid = 1'b1;
      ack_idx   = 3'(i);
      cyc(1);
    end
    ack_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; irq_in = 8'hFF; mask = 8'hFF;
    ack_valid = 1'b0; ack_idx = 3'd0; ovf_clr = 1'b0;

    // Reset dominates with all lines high.
    cyc(1);
    chk("rst_pending1", pend_e, 8'h00);
    chk("rst_any1", {7'd0, any_e}, 8'h00);
    cyc(1);
    chk("rst_pending2", pend_e, 8'h00);
    chk("rst_ovf2", ovf_e, 8'h00);
    rst = 1'b0;
    cyc(2);
    chk("rel_raw_edge2", raw_e, 8'h00);
    cyc(1);
    chk("rel_raw_edge3", raw_e, 8'hFF);
    chk("rel_raw_lvl", raw_l, 8'hFF);

    irq_in = 8'h00;
    cyc(3);
    ack_all();
    chk("cleared", raw_e, 8'h00);

    // Latency and ack on channel 5.
    irq_in = 8'h20;
    cyc(2);
    chk("lat_edge2", raw_e, 8'h00);
    cyc(1);
    chk("lat_edge3", raw_e, 8'h20);
    chk("lat_any", {7'd0, any_e}, 8'h01);
    ack_valid = 1'b1; ack_idx = 3'd5;
    cyc(1);
    ack_valid = 1'b0;
    chk("ack5_pending", pend_e, 8'h00);

    // Set/clear collision on channel 3.
    irq_in = 8'h28;
    cyc(3);
    chk("ch3_set", raw_e & 8'h08, 8'h08);
    irq_in = 8'h20;
    cyc(1);
    irq_in = 8'h28;
    cyc(2);
    ack_valid = 1'b1; ack_idx = 3'd3;
    cyc(1);
    ack_valid = 1'b0;
    chk("coll_raw3", raw_e & 8'h08, 8'h08);
    chk("coll_ovf3", ovf_e & 8'h08, 8'h00);

    // Overflow on channel 0.
    irq_in = irq_in | 8'h01;
    cyc(3);
    irq_in = irq_in & 8'hFE;
    cyc(1);
    irq_in = irq_in | 8'h01;
    cyc(3);
    chk("ovf_set", ovf_e, 8'h01);
    ovf_clr = 1'b1;
    cyc(1);
    ovf_clr = 1'b0;
    chk("ovf_clr", ovf_e, 8'h00);
    irq_in = irq_in & 8'hFE;
    cyc(1);
    irq_in = irq_in | 8'h01;
    cyc(2);
    ovf_clr = 1'b1;
    cyc(1);
    ovf_clr = 1'b0;
    chk("ovf_set_wins", ovf_e, 8'h01);

    // Masking.
    irq_in = 8'h00;
    cyc(3);
    ack_all();
    ovf_clr = 1'b1;
    cyc(1);
    ovf_clr = 1'b0;
    mask   = 8'h0F;
    irq_in = 8'h84;
    cyc(3);
    chk("mask_raw", raw_e, 8'h84);
    chk("mask_pending", pend_e, 8'h04);
    mask = 8'hFF;
    #1;
    chk("mask_open", pend_e, 8'h84);

    // Level mode: held line survives ack, dropped line clears.
    irq_in = irq_in | 8'h02;
    cyc(3);
    ack_valid = 1'b1; ack_idx = 3'd1;
    cyc(1);
    ack_valid = 1'b0;
    chk("lvl_hold", raw_l & 8'h02, 8'h02);
    irq_in = irq_in & 8'hFD;
    cyc(2);
    ack_valid = 1'b1; ack_idx = 3'd1;
    cyc(1);
    ack_valid = 1'b0;
    chk("lvl_clear", raw_l & 8'h02, 8'h00);
    chk("lvl_ovf", ovf_l, 8'h00);

    // Randomised traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < 8; b++) begin
        if ($urandom_range(0, 5) == 0) irq_in[b] = ~irq_in[b];
      end
      if ($urandom_range(0, 15) == 0) mask = 8'($urandom);
      ack_valid = ($urandom_range(0, 2) == 0);
      ack_idx   = 3'($urandom_range(0, 7));
      ovf_clr   = ($urandom_range(0, 19) == 0);
      rst       = ($urandom_range(0, 199) == 0);
      cyc(1);
    end
    rst = 1'b0; ack_valid = 1'b0; ovf_clr = 1'b0;
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/irq_pending_latch.md
Name: irq_pending_latch

Overview:
- Upstream stage of the 8:3 priority encoder.
- Synchronises 8 asynchronous interrupt/request lines and detects events, either rising edges or levels.
- Holds each event as a sticky pending bit until the consumer acknowledges it with the 3-bit index the encoder produced.
- Presents a masked 8-bit pending vector that drives the encoder input directly, plus per-channel overflow flags for events lost while a channel was already pending.

Parameters:
- SYNC_STAGES, 2: number of synchroniser flops per input line; legal range 2..4.
- EDGE_MODE, 1: 1 = capture rising edges; 0 = capture levels (pending re-asserts while the synchronised line stays high).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- irq_in  input  8  asynchronous request lines; bit i = channel i.
- mask  input  8  synchronous enable per channel; 1 = channel visible on pending.
- ack_valid  input  1  one-cycle acknowledge strobe.
- ack_idx  input  3  channel index being acknowledged; same encoding as the encoder output, so 7 = bit 7.
- ovf_clr  input  1  clears all overflow flags.
- pending  output  8  registered raw pending bits ANDed with mask; feeds the encoder.
- any_pending  output  1  OR of pending; combinational from the pending register and mask.
- raw_pending  output  8  registered pending bits before masking.
- overflow  output  8  sticky per-channel overflow flags.

Behaviour:
- Reset (synchronous, rst=1 at a clock edge) clears all of the following to 0: synchroniser flops, previous-sample register, raw_pending, overflow.
  - Consequently pending=0 and any_pending=0 during reset.
  - Reset wins over every other input in the same cycle.
  - Reset mid-operation discards all pending and overflow state.
- Synchroniser: each irq_in bit passes through SYNC_STAGES flops. sync = output of the last stage. prev = sync delayed one clock.
- Event detect, combinational:
  - EDGE_MODE=1: ev[i] = sync[i] & ~prev[i].
  - EDGE_MODE=0: ev[i] = sync[i].
  - A line already high when rst deasserts is seen as a rising edge once synchronised, because prev resets to 0.
- Acknowledge decode: clr[i] = ack_valid & (ack_idx == i).
- raw_pending update, per bit, in priority order:
  - ev[i] → 1. Set wins over a simultaneous clr[i], so the new event is not lost.
  - else clr[i] → 0.
  - else hold.
  - An ack to a bit that is not pending has no effect.
  - An ack clears a masked bit exactly as it clears an unmasked one.
- overflow update, per bit:
  - Set when ev[i] & raw_pending[i] & ~clr[i], i.e. an event arrives on an already-pending channel that is not being acknowledged this cycle.
  - Otherwise cleared when ovf_clr=1.
  - New overflow set wins over a simultaneous ovf_clr.
  - In EDGE_MODE=0 overflow is never set.
- Masking:
  - mask affects only pending and any_pending, with zero-cycle effect.
  - Events on masked channels are still captured in raw_pending and become visible when the mask is opened.
- Latency, EDGE_MODE=1, counting the first clock edge that samples irq_in high as edge 0:
  - raw_pending[i] is 1 after edge SYNC_STAGES.
  - For SYNC_STAGES=2: visible after edge 2, i.e. 3 rising edges.
- Acknowledge latency: raw_pending clears on the edge that samples ack_valid.
  - The encoder sees the next-highest channel in the following cycle.
- Multiple events on different channels in one cycle are all captured. There is no arbitration here; the downstream encoder arbitrates.
- irq_in pulses shorter than one clock period are not guaranteed to be captured. This is documented and not checked.

Test Plan:
- Reset, SYNC_STAGES=2: rst=1 for 2 cycles with irq_in=8'hFF → pending=8'h00, overflow=8'h00, any_pending=0 throughout. Release rst with irq_in still 8'hFF and mask=8'hFF → raw_pending=8'hFF after the 3rd rising edge following release.
- Latency and ack: mask=8'hFF; raise irq_in[5] → raw_pending=8'h20 exactly 3 edges later; any_pending=1. ack_valid=1, ack_idx=5 for one cycle → pending=8'h00 next cycle.
- Set/clear collision: with raw_pending[3]=1, a new rising edge on channel 3 (irq_in[3] drops and re-rises) arranged so ev[3] coincides with ack_valid=1, ack_idx=3 → raw_pending[3] stays 1 and overflow[3] stays 0.
- Overflow: with raw_pending[0]=1 and no ack, pulse irq_in[0] low then high → overflow=8'h01. ovf_clr=1 → overflow=8'h00 next cycle. ovf_clr concurrent with another ev[0] while raw_pending[0]=1 → overflow=8'h01.
- Masking: mask=8'h0F; raise irq_in[7] and irq_in[2] → raw_pending=8'h84, pending=8'h04. Set mask=8'hFF → pending=8'h84 in the same cycle.
- Level mode, EDGE_MODE=0: hold irq_in[1]=1; ack idx 1 → raw_pending[1] stays 1 (set wins). Drop irq_in[1] and ack again → raw_pending[1]=0; overflow stays 8'h00.
